// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MIPS memory stage with word-addressed data memory, branch resolve,
// MEM/WB pipeline register, sticky misalignment flag and load/store counters.
module mem_wb_stage #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MemtoReg,
    input  logic               RegWrite,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic               Branch,
    input  logic               zero,
    input  logic [31:0]        add_result,
    input  logic [31:0]        alu_result,
    input  logic [31:0]        read_data_2,
    input  logic [4:0]         register_dest,
    output logic               PCSrc,
    output logic [31:0]        branch_target,
    output logic               MemtoReg_out,
    output logic               RegWrite_out,
    output logic [31:0]        read_data_out,
    output logic [31:0]        alu_result_out,
    output logic [4:0]         register_dest_out,
    output logic               mem_fault,
    output logic [COUNT_W-1:0] load_count,
    output logic [COUNT_W-1:0] store_count
);
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] addr;
    logic              misaligned;
    logic              do_load;
    logic              do_store;

    // Upper address bits are dropped so accesses wrap modulo DEPTH words
    assign addr          = alu_result[ADDR_W+1:2];
    assign misaligned    = (MemRead | MemWrite) && (alu_result[1:0] != 2'b00);
    assign do_load       = MemRead && !misaligned;
    assign do_store      = MemWrite && !misaligned;
    assign PCSrc         = Branch & zero;
    assign branch_target = add_result;

    always_ff @(posedge clk) begin
        if (!rst && do_store) mem[addr] <= read_data_2;
    end

    // Load reads the pre-edge contents, giving read-before-write on same-cycle access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MemtoReg_out      <= 1'b0;
            RegWrite_out      <= 1'b0;
            read_data_out     <= '0;
            alu_result_out    <= '0;
            register_dest_out <= '0;
            mem_fault         <= 1'b0;
            load_count        <= '0;
            store_count       <= '0;
        end else begin
            MemtoReg_out      <= MemtoReg;
            RegWrite_out      <= RegWrite;
            read_data_out     <= do_load ? mem[addr] : 32'd0;
            alu_result_out    <= alu_result;
            register_dest_out <= register_dest;
            mem_fault         <= mem_fault | misaligned;
            load_count        <= do_load ? load_count + COUNT_W'(1) : load_count;
            store_count       <= do_store ? store_count + COUNT_W'(1) : store_count;
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized and directed checks of mem_wb_stage against an
// array-based memory model; narrow counters so wraparound is exercised.
module tb_mem_wb_stage;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          MemtoReg, RegWrite, MemRead, MemWrite, Branch, zero;
    logic [31:0]   add_result, alu_result, read_data_2;
    logic [4:0]    register_dest;
    logic          PCSrc;
    logic [31:0]   branch_target;
    logic          MemtoReg_out, RegWrite_out;
    logic [31:0]   read_data_out, alu_result_out;
    logic [4:0]    register_dest_out;
    logic          mem_fault;
    logic [CW-1:0] load_count, store_count;

    mem_wb_stage #(.DEPTH(256), .ADDR_W(8), .COUNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .Branch(Branch), .zero(zero), .add_result(add_result), .alu_result(alu_result),
        .read_data_2(read_data_2), .register_dest(register_dest),
        .PCSrc(PCSrc), .branch_target(branch_target),
        .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
        .read_data_out(read_data_out), .alu_result_out(alu_result_out),
        .register_dest_out(register_dest_out), .mem_fault(mem_fault),
        .load_count(load_count), .store_count(store_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [256];
    int          loads  = 0;
    int          stores = 0;
    bit          fault  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic drive_random();
        MemtoReg      = 1'($urandom);
        RegWrite      = 1'($urandom);
        MemRead       = 1'($urandom);
        MemWrite      = 1'($urandom);
        Branch        = 1'($urandom);
        zero          = 1'($urandom);
        add_result    = $urandom;
        alu_result    = $urandom;
        read_data_2   = $urandom;
        register_dest = 5'($urandom);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_memtoreg"}, 32'(MemtoReg_out), 0);
        chk({tag, "_regwrite"}, 32'(RegWrite_out), 0);
        chk({tag, "_rdata"}, read_data_out, 0);
        chk({tag, "_alu"}, alu_result_out, 0);
        chk({tag, "_dst"}, 32'(register_dest_out), 0);
        chk({tag, "_fault"}, 32'(mem_fault), 0);
        chk({tag, "_loads"}, 32'(load_count), 0);
        chk({tag, "_stores"}, 32'(store_count), 0);
    endtask

    task automatic step(input bit mtr, input bit rw, input bit rd, input bit wr,
                        input bit br, input bit z, input logic [31:0] add,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dst);
        int          w;
        bit          mis;
        logic [31:0] er;
        MemtoReg = mtr; RegWrite = rw; MemRead = rd; MemWrite = wr;
        Branch = br; zero = z; add_result = add; alu_result = alu;
        read_data_2 = wd; register_dest = dst;
        #1;
        chk("pcsrc", 32'(PCSrc), 32'(br & z));
        chk("btarget", branch_target, add);
        w   = int'((alu >> 2) % 256);
        mis = (rd || wr) && (alu % 4 != 0);
        er  = (rd && !mis) ? ref_mem[w] : 32'd0;
        if (mis) fault = 1;
        if (rd && !mis) loads++;
        if (wr && !mis) begin
            stores++;
            ref_mem[w] = wd;
        end
        @(posedge clk);
        #1;
        chk("memtoreg", 32'(MemtoReg_out), 32'(mtr));
        chk("regwrite", 32'(RegWrite_out), 32'(rw));
        chk("rdata", read_data_out, er);
        chk("alu", alu_result_out, alu);
        chk("dst", 32'(register_dest_out), 32'(dst));
        chk("fault", 32'(mem_fault), 32'(fault));
        chk("loads", 32'(load_count), 32'(loads % 16));
        chk("stores", 32'(store_count), 32'(stores % 16));
    endtask

    initial begin
        logic [31:0] a;
        drive_random();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst_hold");
        rst = 1'b0;
        for (int i = 0; i < 256; i++)
            step(0, 0, 0, 1, 0, 0, $urandom, 32'(i * 4), $urandom, 5'($urandom));
        step(0, 0, 0, 1, 0, 0, 0, 32'h10, 32'hDEADBEEF, 0);
        step(1, 1, 1, 0, 0, 0, 0, 32'h10, 0, 3);
        step(0, 0, 0, 1, 0, 0, 0, 32'h400, 32'h12345678, 0);
        step(1, 1, 1, 0, 0, 0, 0, 32'h0, 0, 4);
        step(0, 1, 0, 1, 0, 0, 0, 32'h13, 32'hFFFFFFFF, 7);
        step(1, 1, 1, 0, 0, 0, 0, 32'h10, 0, 4);
        step(0, 0, 0, 1, 0, 0, 0, 32'h20, 32'h1, 0);
        step(1, 1, 1, 1, 0, 0, 0, 32'h20, 32'h2, 2);
        step(1, 1, 1, 0, 0, 0, 0, 32'h20, 0, 2);
        step(0, 0, 0, 0, 1, 1, 32'h400, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 32'h400, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 32'h44, 0, 5'd9);
        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            if ($urandom % 8 != 0) a[1:0] = 2'b00;
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), $urandom, a, $urandom, 5'($urandom));
        end
        // Asynchronous reset between edges, with a pending store that must not land
        step(0, 0, 1, 0, 0, 0, 0, 32'h13, 0, 0);
        MemWrite = 1'b1; MemRead = 1'b0; alu_result = 32'h30; read_data_2 = $urandom;
        rst = 1'b1;
        #1;
        chk_zero("rst_async");
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst_async_hold");
        rst = 1'b0;
        fault = 0; loads = 0; stores = 0;
        step(1, 1, 1, 0, 0, 0, 0, 32'h30, 0, 1);
        for (int i = 0; i < 50; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), $urandom, {$urandom} & 32'hFFFF_FFFC, $urandom, 5'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
